// File: rtl/pmem_loader_pkg.sv
// Shared types and constants for the program-memory download engine.
package pmem_loader_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        GET_COUNT,
        GET_HI,
        GET_LO,
        WRITE,
        GET_SUM,
        DONE,
        ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NIBBLE  = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/pmem_loader_if.sv
// Byte-stream input, program-memory load port and status of the loader.
interface pmem_loader_if;
    import pmem_loader_pkg::*;

    logic               start;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               LoadE;
    logic [ADDR_W-1:0]  LoadAddr;
    logic [INSTR_W-1:0] LoadInstruction;
    logic               busy;
    logic               done;
    logic               err;
    logic [1:0]         err_code;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, LoadE, LoadAddr, LoadInstruction, busy, done, err, err_code
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, LoadE, LoadAddr, LoadInstruction, busy, done, err, err_code
    );

endinterface

// File: rtl/pmem_loader_rx_timeout.sv
// Idle-cycle counter between accepted stream bytes; LIMIT of 0 disables it.
module pmem_loader_rx_timeout #(
    parameter logic [15:0] LIMIT = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && LIMIT != 16'd0)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Flags the cycle whose edge brings the count to LIMIT, so the abort
    // happens on that same edge.
    assign expired_o = (LIMIT != 16'd0) && en_i && (cnt_q == LIMIT - 16'd1);

endmodule

// File: rtl/pmem_loader.sv
// Parses count / hi,lo pairs / XOR checksum from a byte stream and writes
// 12-bit instructions to sequential program-memory addresses.
module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 8'h00,
    parameter logic [15:0]       TIMEOUT_CYCLES = 16'd50000
) (
    input  logic          clk,
    input  logic          rst,
    pmem_loader_if.slave  lp
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [8:0]         rem_q, rem_d;
    logic [3:0]         hi_q, hi_d;
    logic [7:0]         csum_q, csum_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               load_e_q, load_e_d;
    logic [ADDR_W-1:0]  load_addr_q, load_addr_d;
    logic [INSTR_W-1:0] load_instr_q, load_instr_d;

    logic get_st, xfer, expired;

    assign get_st = (state_q == GET_COUNT) || (state_q == GET_HI) ||
                    (state_q == GET_LO)    || (state_q == GET_SUM);
    assign xfer   = lp.in_valid && get_st;

    pmem_loader_rx_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!get_st || xfer),
        .en_i      (get_st),
        .expired_o (expired)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        hi_d         = hi_q;
        csum_d       = csum_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        code_d       = code_q;
        load_e_d     = 1'b0;
        load_addr_d  = load_addr_q;
        load_instr_d = load_instr_q;

        if (get_st && expired) begin
            state_d = ERROR;
            code_d  = ERR_TIMEOUT;
        end else begin
            case (state_q)
                IDLE: if (lp.start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    busy_d  = 1'b1;
                    csum_d  = '0;
                    addr_d  = BASE_ADDR;
                    state_d = GET_COUNT;
                end
                GET_COUNT: if (xfer) begin
                    rem_d   = (lp.in_data == 8'h00) ? 9'd256 : {1'b0, lp.in_data};
                    csum_d  = csum_q ^ lp.in_data;
                    state_d = GET_HI;
                end
                GET_HI: if (xfer) begin
                    if (lp.in_data[7:4] != 4'h0) begin
                        state_d = ERROR;
                        code_d  = ERR_NIBBLE;
                    end else begin
                        hi_d    = lp.in_data[3:0];
                        csum_d  = csum_q ^ lp.in_data;
                        state_d = GET_LO;
                    end
                end
                GET_LO: if (xfer) begin
                    csum_d       = csum_q ^ lp.in_data;
                    load_e_d     = 1'b1;
                    load_addr_d  = addr_q;
                    load_instr_d = {hi_q, lp.in_data};
                    state_d      = WRITE;
                end
                WRITE: begin
                    addr_d  = addr_q + 8'd1;
                    rem_d   = rem_q - 9'd1;
                    state_d = (rem_q == 9'd1) ? GET_SUM : GET_HI;
                end
                GET_SUM: if (xfer) begin
                    if (lp.in_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                        code_d  = ERR_CSUM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // DONE/ERROR last one cycle, so these fire only on entry.
        if (state_d == ERROR) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
        end
        if (state_d == DONE) begin
            done_d = 1'b1;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= BASE_ADDR;
            rem_q        <= '0;
            hi_q         <= '0;
            csum_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= ERR_NONE;
            load_e_q     <= 1'b0;
            load_addr_q  <= '0;
            load_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            hi_q         <= hi_d;
            csum_q       <= csum_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            code_q       <= code_d;
            load_e_q     <= load_e_d;
            load_addr_q  <= load_addr_d;
            load_instr_q <= load_instr_d;
        end
    end

    assign lp.in_ready        = get_st;
    assign lp.LoadE           = load_e_q;
    assign lp.LoadAddr        = load_addr_q;
    assign lp.LoadInstruction = load_instr_q;
    assign lp.busy            = busy_q;
    assign lp.done            = done_q;
    assign lp.err             = err_q;
    assign lp.err_code        = code_q;

endmodule

// File: tb/tb_pmem_loader.sv
// Directed bench: dut_a (base 00, timeout 16) and dut_b (base FF, no timeout)
// share the byte stream; only the started loader consumes it.
module tb_pmem_loader;

    logic       clk, rst;
    logic       start_a, start_b, vld, sel;
    logic [7:0] dat;

    pmem_loader_if ifa();
    pmem_loader_if ifb();

    assign ifa.start    = start_a;
    assign ifa.in_valid = vld;
    assign ifa.in_data  = dat;
    assign ifb.start    = start_b;
    assign ifb.in_valid = vld;
    assign ifb.in_data  = dat;

    pmem_loader #(.BASE_ADDR(8'h00), .TIMEOUT_CYCLES(16'd16)) dut_a (
        .clk(clk), .rst(rst), .lp(ifa)
    );
    pmem_loader #(.BASE_ADDR(8'hFF), .TIMEOUT_CYCLES(16'd0)) dut_b (
        .clk(clk), .rst(rst), .lp(ifb)
    );

    // Observed loader, selected by sel.
    logic        rdy, le, busy, done, err;
    logic [1:0]  code;
    logic [7:0]  la;
    logic [11:0] ld;
    assign rdy  = sel ? ifb.in_ready        : ifa.in_ready;
    assign le   = sel ? ifb.LoadE           : ifa.LoadE;
    assign la   = sel ? ifb.LoadAddr        : ifa.LoadAddr;
    assign ld   = sel ? ifb.LoadInstruction : ifa.LoadInstruction;
    assign busy = sel ? ifb.busy            : ifa.busy;
    assign done = sel ? ifb.done            : ifa.done;
    assign err  = sel ? ifb.err             : ifa.err;
    assign code = sel ? ifb.err_code        : ifa.err_code;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log of the observed loader.
    int          nw = 0;
    int          badrdy = 0;
    logic [7:0]  waddr [0:511];
    logic [11:0] wdata [0:511];
    always @(posedge clk) begin
        #1;
        if (le) begin
            waddr[nw] = la;
            wdata[nw] = ld;
            nw = nw + 1;
            if (rdy) badrdy = badrdy + 1;
        end
    end

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a negedge.
    task automatic pulse_start();
        repeat (2) @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        vld = 1'b1;
        dat = b;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) chk("send_stall", 0, 1);
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic send_good(input bit gaps, input logic [7:0] last);
        logic [7:0] s [0:5];
        s[0] = 8'h02; s[1] = 8'h0A; s[2] = 8'hBC;
        s[3] = 8'h03; s[4] = 8'h4D; s[5] = last;
        for (int i = 0; i < 6; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
            send(s[i]);
        end
    endtask

    int w0;
    int cyc;

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; vld = 1'b0; dat = 8'h00; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_status", int'({busy, done, err, code, le, rdy}), 0);
        chk("rst_laddr",  int'(ifb.LoadAddr), 0);
        chk("rst_linstr", int'(ld), 0);
        rst = 1'b0;

        // Good load on A
        w0 = nw;
        pulse_start();
        chk("good_busy", int'(busy), 1);
        send_good(1'b0, 8'hFA);
        chk("good_nw",    nw - w0, 2);
        chk("good_a0",    int'(waddr[w0]), 'h00);
        chk("good_d0",    int'(wdata[w0]), 'hABC);
        chk("good_a1",    int'(waddr[w0+1]), 'h01);
        chk("good_d1",    int'(wdata[w0+1]), 'h34D);
        chk("good_done",  int'({done, err, busy}), 'b100);

        // Bad high nibble
        w0 = nw;
        pulse_start();
        send(8'h01);
        send(8'h1A);
        chk("nib_err",   int'({done, err, code}), 'b0101);
        chk("nib_ready", int'(rdy), 0);
        repeat (3) @(negedge clk);
        chk("nib_nw",    nw - w0, 0);

        // Checksum mismatch
        w0 = nw;
        pulse_start();
        send_good(1'b0, 8'hFB);
        chk("csum_nw",  nw - w0, 2);
        chk("csum_err", int'({done, err, code, busy}), 'b01100);

        // Timeout: 16 idle cycles after the count byte
        w0 = nw;
        pulse_start();
        send(8'h01);
        cyc = 0;
        while (!err && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_cycles", cyc, 16);
        chk("tmo_code",   int'({err, code, busy}), 'b1110);
        chk("tmo_nw",     nw - w0, 0);

        // start pulsed mid-load is ignored
        w0 = nw;
        pulse_start();
        send(8'h02);
        pulse_start();
        send(8'h0A); send(8'hBC); send(8'h03); send(8'h4D); send(8'hFA);
        chk("midst_nw",   nw - w0, 2);
        chk("midst_a1",   int'(waddr[w0+1]), 'h01);
        chk("midst_d1",   int'(wdata[w0+1]), 'h34D);
        chk("midst_done", int'({done, err}), 'b10);

        // Wrap from FF with random stream gaps on B
        sel = 1'b1;
        repeat (2) @(negedge clk);
        w0 = nw;
        badrdy = 0;
        pulse_start();
        send_good(1'b1, 8'hFA);
        chk("wrap_nw",    nw - w0, 2);
        chk("wrap_a0",    int'(waddr[w0]), 'hFF);
        chk("wrap_d0",    int'(wdata[w0]), 'hABC);
        chk("wrap_a1",    int'(waddr[w0+1]), 'h00);
        chk("wrap_d1",    int'(wdata[w0+1]), 'h34D);
        chk("wrap_rdy",   badrdy, 0);
        chk("wrap_done",  int'({done, err, busy}), 'b100);

        // Reset after the first write, then a fresh load
        pulse_start();
        send(8'h02); send(8'h0A); send(8'hBC);
        chk("rstm_le",   int'({le, la}), 'h1FF);
        rst = 1'b1;
        @(negedge clk);
        chk("rstm_status", int'({busy, done, err, code, le, rdy}), 0);
        chk("rstm_laddr",  int'(la), 0);
        chk("rstm_linstr", int'(ld), 0);
        rst = 1'b0;
        w0 = nw;
        pulse_start();
        send_good(1'b0, 8'hFA);
        chk("fresh_nw",   nw - w0, 2);
        chk("fresh_a0",   int'(waddr[w0]), 'hFF);
        chk("fresh_a1",   int'(waddr[w0+1]), 'h00);
        chk("fresh_done", int'({done, err, busy}), 'b100);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
